// File: rtl/taillamp_frame_decoder_if.sv
// Lamp frame stream and decoder status bundle for taillamp_frame_decoder.
// The master side drives frames and clr; the slave side is the decoder.
interface taillamp_frame_decoder_if;
  logic [0:9] frame_in;
  logic       frame_valid;
  logic       clr;
  logic [1:0] mode;
  logic [3:0] seq_count;
  logic       seq_done;
  logic       stall;
  logic       frame_err;
  logic [7:0] dLED;

  modport master (
    output frame_in, frame_valid, clr,
    input  mode, seq_count, seq_done, stall, frame_err, dLED
  );

  modport slave (
    input  frame_in, frame_valid, clr,
    output mode, seq_count, seq_done, stall, frame_err, dLED
  );
endinterface

// File: rtl/taillamp_frame_decoder.sv
// Tail-lamp frame stream checker: locks turn mode from the opening frame, flags violations,
// counts completed sequences. Define TAILDEC_TIMEOUT_EN to add the idle-timeout abandon.
module taillamp_frame_decoder #(
  parameter int unsigned MAX_FRAMES = 48,
  parameter int unsigned SEQ_LIMIT  = 9
`ifdef TAILDEC_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYC = 10000000
`endif
) (
  input logic                  clk,
  input logic                  RESET,
  taillamp_frame_decoder_if.slave bus
);

  localparam int unsigned FcW = $clog2(MAX_FRAMES + 1);
  localparam logic [3:0]  SeqLim = 4'(SEQ_LIMIT);

  typedef enum logic [1:0] {StIdle, StRun, StGap, StDone} state_e;

  state_e           state_q;
  logic [1:0]       mode_q;
  logic [3:0]       count_q;
  logic [FcW-1:0]   fcnt_q;
  logic             done_q;
  logic             stall_q;
  logic             err_q;
  logic [7:0]       led_q;

`ifdef TAILDEC_TIMEOUT_EN
  localparam int unsigned ToW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [ToW-1:0] tcnt_q;
`endif

  logic [0:9]     frame;
  logic           violation;
  logic [3:0]     count_inc;
  logic [FcW-1:0] fcnt_inc;

  function automatic logic [7:0] seg_code(logic [3:0] v);
    case (v)
      4'd0:    seg_code = 8'b01000000;
      4'd1:    seg_code = 8'b01111001;
      4'd2:    seg_code = 8'b00100100;
      4'd3:    seg_code = 8'b00110000;
      4'd4:    seg_code = 8'b00011001;
      4'd5:    seg_code = 8'b00010010;
      4'd6:    seg_code = 8'b00000010;
      4'd7:    seg_code = 8'b01111000;
      4'd8:    seg_code = 8'b00000000;
      4'd9:    seg_code = 8'b00010000;
      default: seg_code = 8'b01000000;
    endcase
  endfunction

  always_comb begin
    frame     = bus.frame_in;
    // Single-side modes may only light their own half; full mode accepts anything.
    violation = ((mode_q == 2'b10) && (|frame[0:4])) ||
                ((mode_q == 2'b11) && (|frame[5:9]));
    count_inc = (count_q == SeqLim) ? count_q : count_q + 4'd1;
    fcnt_inc  = fcnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      state_q <= StIdle;
      mode_q  <= 2'b00;
      count_q <= 4'd0;
      fcnt_q  <= '0;
      done_q  <= 1'b0;
      stall_q <= 1'b0;
      err_q   <= 1'b0;
      led_q   <= 8'b01000000;
`ifdef TAILDEC_TIMEOUT_EN
      tcnt_q  <= '0;
`endif
    end else begin
      done_q  <= 1'b0;
      stall_q <= 1'b0;
      if (bus.clr) begin
        state_q <= StIdle;
        mode_q  <= 2'b00;
        count_q <= 4'd0;
        fcnt_q  <= '0;
        err_q   <= 1'b0;
        led_q   <= seg_code(4'd0);
`ifdef TAILDEC_TIMEOUT_EN
        tcnt_q  <= '0;
`endif
      end else if (bus.frame_valid) begin
`ifdef TAILDEC_TIMEOUT_EN
        tcnt_q <= '0;
`endif
        unique case (state_q)
          StIdle: begin
            if (frame == 10'b0000110000 || frame == 10'b0000010000 ||
                frame == 10'b0000100000) begin
              unique case (frame)
                10'b0000110000: mode_q <= 2'b01;
                10'b0000010000: mode_q <= 2'b10;
                default:        mode_q <= 2'b11;
              endcase
              fcnt_q  <= FcW'(1);
              state_q <= StRun;
            end
          end
          StRun, StGap: begin
            if (state_q == StGap && frame == 10'b0) begin
              count_q <= count_inc;
              led_q   <= seg_code(count_inc);
              done_q  <= 1'b1;
              mode_q  <= 2'b00;
              fcnt_q  <= '0;
              state_q <= (count_inc == SeqLim) ? StDone : StIdle;
            end else begin
              if (violation) err_q <= 1'b1;
              // Completion was ruled out above, so hitting the limit here is an overrun.
              if (fcnt_inc >= FcW'(MAX_FRAMES)) begin
                err_q   <= 1'b1;
                mode_q  <= 2'b00;
                fcnt_q  <= '0;
                state_q <= StIdle;
              end else begin
                fcnt_q  <= fcnt_inc;
                state_q <= (frame == 10'b0) ? StGap : StRun;
              end
            end
          end
          StDone: ;
          default: state_q <= StIdle;
        endcase
      end
`ifdef TAILDEC_TIMEOUT_EN
      else if (state_q == StRun || state_q == StGap) begin
        if (tcnt_q == ToW'(TIMEOUT_CYC - 1)) begin
          stall_q <= 1'b1;
          mode_q  <= 2'b00;
          fcnt_q  <= '0;
          tcnt_q  <= '0;
          state_q <= StIdle;
        end else begin
          tcnt_q <= tcnt_q + 1'b1;
        end
      end else begin
        tcnt_q <= '0;
      end
`endif
    end
  end

  assign bus.mode      = mode_q;
  assign bus.seq_count = count_q;
  assign bus.seq_done  = done_q;
  assign bus.stall     = stall_q;
  assign bus.frame_err = err_q;
  assign bus.dLED      = led_q;

endmodule

// File: tb/tb_taillamp_frame_decoder.sv
// Scoreboard bench for taillamp_frame_decoder: sequence-level reference model,
// randomized lamp sequences, monitor process checking every seq_done/stall pulse.
module tb_taillamp_frame_decoder;
  localparam logic [9:0] OpenFull  = 10'b0000110000;
  localparam logic [9:0] OpenRight = 10'b0000010000;
  localparam logic [9:0] OpenLeft  = 10'b0000100000;
  localparam int TimeoutCyc = 64;

  logic clk = 1'b0;
  logic RESET;
  always #5 clk = ~clk;

  taillamp_frame_decoder_if bus();

  taillamp_frame_decoder #(
    .MAX_FRAMES(48),
    .SEQ_LIMIT(9)
`ifdef TAILDEC_TIMEOUT_EN
    , .TIMEOUT_CYC(TimeoutCyc)
`endif
  ) dut (
    .clk(clk),
    .RESET(RESET),
    .bus(bus)
  );

  typedef struct {
    bit is_stall;
    int cnt;
    int md;
    bit err;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  // Reference model: 0 idle, 1 in sequence, 2 one blank seen, 3 done.
  int m_phase, m_mode, m_count, m_frames;
  bit m_err;

  function automatic logic [7:0] seg_ref(int v);
    logic [7:0] tab [0:9];
    tab = '{8'h40, 8'h79, 8'h24, 8'h30, 8'h19, 8'h12, 8'h02, 8'h78, 8'h00, 8'h10};
    return (v >= 0 && v <= 9) ? tab[v] : 8'h40;
  endfunction

  function automatic void model_clear();
    m_phase = 0; m_mode = 0; m_count = 0; m_frames = 0; m_err = 0;
  endfunction

  function automatic void model_frame(logic [9:0] f);
    bit left_lit  = |f[9:5];
    bit right_lit = |f[4:0];
    if (m_phase == 0) begin
      if (f == OpenFull)  m_mode = 1;
      if (f == OpenRight) m_mode = 2;
      if (f == OpenLeft)  m_mode = 3;
      if (m_mode != 0) begin
        m_frames = 1;
        m_phase  = 1;
      end
    end else if (m_phase == 2 && f == 10'd0) begin
      m_count = (m_count < 9) ? m_count + 1 : 9;
      m_mode  = 0;
      m_phase = (m_count == 9) ? 3 : 0;
      exp_q.push_back('{0, m_count, 0, m_err});
    end else if (m_phase != 3) begin
      if ((m_mode == 2 && left_lit) || (m_mode == 3 && right_lit)) m_err = 1;
      m_frames++;
      if (m_frames >= 48) begin
        m_err = 1; m_mode = 0; m_phase = 0;
      end else begin
        m_phase = (f == 10'd0) ? 2 : 1;
      end
    end
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp,
               $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, " mode"}, int'(bus.mode), m_mode);
    chk({tag, " seq_count"}, int'(bus.seq_count), m_count);
    chk({tag, " frame_err"}, int'(bus.frame_err), int'(m_err));
    chk({tag, " dLED"}, int'(bus.dLED), int'(seg_ref(m_count)));
  endtask

  task automatic send(input logic [9:0] f);
    @(negedge clk);
    bus.frame_in    = f;
    bus.frame_valid = 1'b1;
    model_frame(f);
    @(negedge clk);
    bus.frame_valid = 1'b0;
    check_outputs("frame");
  endtask

  task automatic do_clr(input bit with_frame);
    @(negedge clk);
    bus.clr         = 1'b1;
    bus.frame_valid = with_frame;
    bus.frame_in    = 10'd0;
    model_clear();
    @(negedge clk);
    bus.clr         = 1'b0;
    bus.frame_valid = 1'b0;
    check_outputs("clr");
  endtask

  // One sequence: opening frame, body with optional single blanks, closing double blank.
  task automatic run_seq(input int md, input int body, input bit allow_bad);
    logic [9:0] open, mask, f;
    bit prev_blank = 0;
    open = (md == 1) ? OpenFull : (md == 2) ? OpenRight : OpenLeft;
    mask = (md == 1) ? 10'h3FF : (md == 2) ? 10'h01F : 10'h3E0;
    send(open);
    for (int i = 0; i < body; i++) begin
      if (!prev_blank && $urandom_range(0, 7) == 0) begin
        f = 10'd0;
      end else begin
        f = 10'($urandom) & mask;
        if (allow_bad && $urandom_range(0, 7) == 0) f = 10'($urandom);
        if (f == 10'd0) f = open;
      end
      prev_blank = (f == 10'd0);
      send(f);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    send(10'd0);
    send(10'd0);
  endtask

  // Scoreboard monitor
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (bus.seq_done === 1'b1 || bus.stall === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pulse: unexpected seq_done=%b stall=%b at %0t", bus.seq_done, bus.stall,
                   $time);
        end else begin
          e = exp_q.pop_front();
          chk("pulse stall", int'(bus.stall), int'(e.is_stall));
          chk("pulse seq_count", int'(bus.seq_count), e.cnt);
          chk("pulse mode", int'(bus.mode), e.md);
          chk("pulse frame_err", int'(bus.frame_err), int'(e.err));
        end
      end
    end
  end

  initial begin
    bus.frame_in    = 10'd0;
    bus.frame_valid = 1'b0;
    bus.clr         = 1'b0;
    RESET           = 1'b0;
    model_clear();
    #12;
    chk("reset mode", int'(bus.mode), 0);
    chk("reset seq_count", int'(bus.seq_count), 0);
    chk("reset frame_err", int'(bus.frame_err), 0);
    chk("reset seq_done", int'(bus.seq_done), 0);
    chk("reset stall", int'(bus.stall), 0);
    chk("reset dLED", int'(bus.dLED), 8'b01000000);
    RESET = 1'b1;

    // Full mode, 45 frames total
    run_seq(1, 42, 0);
    chk("full seq dLED", int'(bus.dLED), 8'b01111001);
    chk("full seq count", int'(bus.seq_count), 1);

    // Right-only violation stays sticky, sequence still completes
    send(OpenRight);
    send(10'b1000000000);
    chk("violation err", int'(bus.frame_err), 1);
    send(10'b0000000011);
    send(10'd0);
    send(10'd0);
    chk("violation count", int'(bus.seq_count), 2);

    // Idle timeout (or indefinite wait without it)
    send(OpenLeft);
`ifdef TAILDEC_TIMEOUT_EN
    exp_q.push_back('{1, m_count, 0, m_err});
    m_phase = 0; m_mode = 0;
`endif
    repeat (TimeoutCyc + 40) @(negedge clk);
    chk("timeout mode", int'(bus.mode), m_mode);
    send(10'd0);
    send(10'd0);

    // Overrun: 48 lit frames after opening, no double blank
    do_clr(0);
    send(OpenFull);
    for (int i = 0; i < 48; i++) send(10'h3FF);
    chk("overrun err", int'(bus.frame_err), 1);
    chk("overrun mode", int'(bus.mode), 0);
    chk("overrun count", int'(bus.seq_count), 0);

    // clr wins over a same-cycle frame
    send(OpenFull);
    send(10'd0);
    do_clr(1);

    // Nine sequences reach DONE, tenth opening ignored
    for (int s = 0; s < 9; s++) run_seq(1, 5, 0);
    send(OpenFull);
    send(10'd0);
    send(10'd0);
    chk("done count", int'(bus.seq_count), 9);
    chk("done dLED", int'(bus.dLED), 8'b00010000);
    do_clr(0);
    chk("after clr dLED", int'(bus.dLED), 8'b01000000);

    // Randomized sequences
    for (int s = 0; s < 14; s++) begin
      if ($urandom_range(0, 4) == 0) do_clr(0);
      send(10'($urandom));
      run_seq($urandom_range(1, 3), $urandom_range(2, 55), 1'($urandom_range(0, 1)));
    end

    // Asynchronous reset mid-sequence
    do_clr(0);
    send(OpenRight);
    send(10'b0000000101);
    #2;
    RESET = 1'b0;
    model_clear();
    #1;
    chk("async reset mode", int'(bus.mode), 0);
    chk("async reset count", int'(bus.seq_count), 0);
    chk("async reset err", int'(bus.frame_err), 0);
    chk("async reset dLED", int'(bus.dLED), 8'b01000000);
    @(negedge clk);
    RESET = 1'b1;
    run_seq(2, 6, 0);

    repeat (3) @(negedge clk);
    chk("scoreboard drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end
endmodule
